// File: rtl/instr_queue_mp.sv
// instr_queue_mp: multi-port circular instruction queue packing sparse fetch lanes and exposing the oldest ID_WIDTH entries to decode.
module instr_queue_mp #(
  parameter int IF_WIDTH   = 2,
  parameter int ID_WIDTH   = 2,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [IF_WIDTH-1:0]            fe_valid_i,
  input  logic [IF_WIDTH*DATA_WIDTH-1:0] fe_data_i,
  output logic                           fe_ready_o,
  output logic [ID_WIDTH-1:0]            be_valid_o,
  output logic [ID_WIDTH*DATA_WIDTH-1:0] be_data_o,
  input  logic [ID_WIDTH-1:0]            be_accept_i,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, n_push, n_pop;
  logic push, stop;
  // Readiness uses only the registered count; a same-cycle pop never frees room for a push.
  assign fe_ready_o = int'(count_q) + IF_WIDTH <= DEPTH;
  assign push       = fe_ready_o && |fe_valid_i && !flush_i;
  assign count_o    = count_q;
  always_comb begin
    mem_d  = mem_q;
    n_push = '0;
    n_pop  = '0;
    stop   = 1'b0;
    for (int i = 0; i < IF_WIDTH; i++) begin
      if (push && fe_valid_i[i]) begin
        mem_d[wr_ptr_q + PW'(n_push)] = fe_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        n_push = n_push + CW'(1);
      end
    end
    // Pop only the contiguous accepted prefix, and never past the valid entries.
    for (int i = 0; i < ID_WIDTH; i++) begin
      stop  = stop || !be_accept_i[i] || int'(count_q) <= i;
      n_pop = stop ? n_pop : n_pop + CW'(1);
    end
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + PW'(n_pop);
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + PW'(n_push);
    count_d  = flush_i ? '0 : count_q + n_push - n_pop;
  end
  always_comb begin
    be_valid_o = '0;
    be_data_o  = '0;
    for (int i = 0; i < ID_WIDTH; i++) begin
      be_valid_o[i] = int'(count_q) > i;
      be_data_o[i*DATA_WIDTH +: DATA_WIDTH] = be_valid_o[i] ? mem_q[rd_ptr_q + PW'(i)] : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (count_q <= CW'(DEPTH)) else $error("instr_queue_mp: count %0d exceeds depth", count_q);
      assert ((be_accept_i & ~be_valid_o) == '0 && (be_accept_i & ID_WIDTH'(be_accept_i + 1'b1)) == '0)
        else $warning("instr_queue_mp: be_accept_i %b is not a prefix of be_valid_o %b", be_accept_i, be_valid_o);
    end
  end
`endif
endmodule

// File: tb/tb_instr_queue_mp.sv
// tb_instr_queue_mp: directed and randomized checks of instr_queue_mp against a queue-based reference model.
module tb_instr_queue_mp;
  localparam int IFW = 2, IDW = 2, DEPTH = 8, DW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic [IFW-1:0] fe_valid_i = '0;
  logic [IFW*DW-1:0] fe_data_i = '0;
  logic fe_ready_o;
  logic [IDW-1:0] be_valid_o;
  logic [IDW*DW-1:0] be_data_o;
  logic [IDW-1:0] be_accept_i = '0;
  logic [3:0] count_o;
  int checks = 0, errors = 0;
  logic [DW-1:0] q[$];

  instr_queue_mp #(.IF_WIDTH(IFW), .ID_WIDTH(IDW), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .fe_valid_i(fe_valid_i), .fe_data_i(fe_data_i),
    .fe_ready_o(fe_ready_o), .be_valid_o(be_valid_o), .be_data_o(be_data_o),
    .be_accept_i(be_accept_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [IDW-1:0] m_valid();
    logic [IDW-1:0] v = '0;
    for (int i = 0; i < IDW; i++) v[i] = q.size() > i;
    return v;
  endfunction

  function automatic logic [IDW*DW-1:0] m_data();
    logic [IDW*DW-1:0] d = '0;
    for (int i = 0; i < IDW; i++) if (q.size() > i) d[i*DW +: DW] = q[i];
    return d;
  endfunction

  function automatic logic m_ready();
    return q.size() + IFW <= DEPTH;
  endfunction

  // Advance one clock and apply the queue rules to the reference model.
  task automatic tick();
    int sz = q.size();
    int np = 0;
    bit rdy = m_ready();
    for (int i = 0; i < IDW; i++) begin
      if (be_accept_i[i] && i < sz) np++;
      else break;
    end
    @(posedge clk);
    #1;
    if (flush_i) q.delete();
    else begin
      repeat (np) void'(q.pop_front());
      if (rdy) for (int i = 0; i < IFW; i++) if (fe_valid_i[i]) q.push_back(fe_data_i[i*DW +: DW]);
    end
  endtask

  task automatic idle();
    fe_valid_i = '0;
    be_accept_i = '0;
    flush_i = 1'b0;
  endtask

  task automatic push(input logic [1:0] v, input logic [DW-1:0] l1, input logic [DW-1:0] l0);
    fe_valid_i = v;
    fe_data_i = {l1, l0};
    tick();
    idle();
  endtask

  task automatic do_flush();
    idle();
    flush_i = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    q.delete();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    checks++; if (be_valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", be_valid_o); end
    checks++; if (be_data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", be_data_o); end
    checks++; if (fe_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", fe_ready_o); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_push_pair();
    push(2'b11, 32'hBBBB_0002, 32'hAAAA_0001);
    checks++; if (be_valid_o !== 2'b11) begin errors++; $display("FAIL pair_valid: got %b expected 11", be_valid_o); end
    checks++; if (be_data_o !== {32'hBBBB_0002, 32'hAAAA_0001}) begin errors++; $display("FAIL pair_data: got %h expected %h", be_data_o, {32'hBBBB_0002, 32'hAAAA_0001}); end
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL pair_count: got %0d expected 2", count_o); end
    checks++; if (fe_ready_o !== 1'b1) begin errors++; $display("FAIL pair_ready: got %b expected 1", fe_ready_o); end
  endtask

  task automatic test_packing();
    do_flush();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL pack_flush_count: got %0d expected 0", count_o); end
    push(2'b10, 32'hCCCC_0003, 32'hDEAD_BEEF);
    checks++; if (be_valid_o !== 2'b01) begin errors++; $display("FAIL pack_valid: got %b expected 01", be_valid_o); end
    checks++; if (be_data_o !== {32'h0, 32'hCCCC_0003}) begin errors++; $display("FAIL pack_data: got %h expected %h", be_data_o, {32'h0, 32'hCCCC_0003}); end
    checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL pack_count: got %0d expected 1", count_o); end
  endtask

  task automatic test_full();
    do_flush();
    for (int i = 0; i < 4; i++) push(2'b11, 32'h1000 + 2 * i + 1, 32'h1000 + 2 * i);
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", count_o); end
    checks++; if (fe_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", fe_ready_o); end
    checks++; if (be_valid_o !== 2'b11) begin errors++; $display("FAIL full_valid: got %b expected 11", be_valid_o); end
    fe_valid_i = 2'b11;
    fe_data_i = {32'hF00D_0001, 32'hF00D_0000};
    be_accept_i = 2'b11;
    tick();
    idle();
    checks++; if (count_o !== 4'd6) begin errors++; $display("FAIL full_pop_count: got %0d expected 6", count_o); end
    checks++; if (fe_ready_o !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b expected 1", fe_ready_o); end
    checks++; if (be_data_o !== {32'h1003, 32'h1002}) begin errors++; $display("FAIL full_pop_data: got %h expected %h", be_data_o, {32'h1003, 32'h1002}); end
  endtask

  task automatic test_wrap();
    do_flush();
    for (int i = 0; i < 3; i++) push(2'b11, 32'h2000 + 2 * i + 1, 32'h2000 + 2 * i);
    push(2'b01, 32'h0, 32'h2006);
    for (int i = 0; i < 3; i++) begin
      be_accept_i = 2'b11;
      tick();
    end
    be_accept_i = 2'b01;
    tick();
    idle();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL wrap_drain_count: got %0d expected 0", count_o); end
    push(2'b11, 32'hEEEE_0005, 32'hDDDD_0004);
    checks++; if (be_data_o !== {32'hEEEE_0005, 32'hDDDD_0004}) begin errors++; $display("FAIL wrap_data: got %h expected %h", be_data_o, {32'hEEEE_0005, 32'hDDDD_0004}); end
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", count_o); end
    be_accept_i = 2'b11;
    tick();
    idle();
    checks++; if (count_o !== 4'd0 || be_valid_o !== 2'b00) begin errors++; $display("FAIL wrap_pop: got count %0d valid %b expected count 0 valid 00", count_o, be_valid_o); end
    push(2'b01, 32'h0, 32'h7777_0007);
    checks++; if (be_data_o !== {32'h0, 32'h7777_0007}) begin errors++; $display("FAIL wrap_next_data: got %h expected %h", be_data_o, {32'h0, 32'h7777_0007}); end
  endtask

  task automatic test_nonprefix();
    do_flush();
    push(2'b11, 32'h3001, 32'h3000);
    push(2'b10, 32'h3002, 32'h0);
    fe_valid_i = 2'b11;
    fe_data_i = {32'h3004, 32'h3003};
    be_accept_i = 2'b10;
    tick();
    idle();
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL nonprefix_count: got %0d expected 5", count_o); end
    checks++; if (be_data_o !== {32'h3001, 32'h3000}) begin errors++; $display("FAIL nonprefix_head: got %h expected %h", be_data_o, {32'h3001, 32'h3000}); end
    checks++; if (be_data_o !== m_data()) begin errors++; $display("FAIL nonprefix_model: got %h expected %h", be_data_o, m_data()); end
  endtask

  task automatic test_flush_reset();
    do_flush();
    push(2'b11, 32'h4001, 32'h4000);
    push(2'b11, 32'h4003, 32'h4002);
    flush_i = 1'b1;
    fe_valid_i = 2'b11;
    fe_data_i = {32'h4005, 32'h4004};
    be_accept_i = 2'b11;
    #1;
    checks++; if (be_valid_o !== 2'b11 || be_data_o !== {32'h4001, 32'h4000}) begin errors++; $display("FAIL flush_cycle_old: got valid %b data %h expected 11 %h", be_valid_o, be_data_o, {32'h4001, 32'h4000}); end
    tick();
    idle();
    checks++; if (count_o !== 4'd0 || be_valid_o !== 2'b00) begin errors++; $display("FAIL flush: got count %0d valid %b expected 0 00", count_o, be_valid_o); end
    push(2'b11, 32'h4007, 32'h4006);
    push(2'b01, 32'h0, 32'h4008);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", count_o); end
    checks++; if (be_valid_o !== 2'b00 || be_data_o !== '0 || fe_ready_o !== 1'b1) begin errors++; $display("FAIL async_reset_out: got valid %b data %h ready %b expected 00 0 1", be_valid_o, be_data_o, fe_ready_o); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int sz = q.size();
      int na = $urandom_range(0, sz < IDW ? sz : IDW);
      fe_valid_i = 2'($urandom_range(0, 3));
      fe_data_i = {$urandom, $urandom};
      be_accept_i = na == 0 ? 2'b00 : na == 1 ? 2'b01 : 2'b11;
      flush_i = $urandom_range(0, 24) == 0;
      tick();
      checks++; if (count_o !== 4'(q.size())) begin errors++; $display("FAIL rand_count c=%0d: got %0d expected %0d", c, count_o, q.size()); end
      checks++; if (be_valid_o !== m_valid()) begin errors++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, be_valid_o, m_valid()); end
      checks++; if (be_data_o !== m_data()) begin errors++; $display("FAIL rand_data c=%0d: got %h expected %h", c, be_data_o, m_data()); end
      checks++; if (fe_ready_o !== m_ready()) begin errors++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, fe_ready_o, m_ready()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_push_pair();
    test_packing();
    test_full();
    test_wrap();
    test_nonprefix();
    test_flush_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
